pulse_sequencer: RTL and testbench

Note sequencer driving one pulse_channel voice: the producer side of the note_on / note_trigger / phase_inc interface. Steps through an 8-bit pattern ROM, one step per song tick. Decodes note indices to phase increments and prefetches the next step so its trigger is valid when the song tick lands. Sits between song timing logic and the voice.

---
 rtl/pulse_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_pulse_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sequencer.sv
// Pattern-ROM note sequencer feeding one pulse_channel voice: fetches, decodes and
// stages the next step ahead of the song tick. Optional macro: PULSE_SEQ_TRANSPOSE_EN.
module pulse_sequencer #(
  parameter int unsigned PHASE_BITS = 18,
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned LOOP_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_clk,
  input  logic                  song_clk,
  input  logic                  start,
  input  logic                  stop,
  output logic [ADDR_BITS-1:0]  rom_addr,
  input  logic [7:0]            rom_data,
`ifdef PULSE_SEQ_TRANSPOSE_EN
  input  logic [4:0]            transpose,
`endif
  output logic                  note_on,
  output logic                  note_trigger,
  output logic [PHASE_BITS-1:0] phase_inc,
  output logic                  playing,
  output logic                  underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_READ, S_DECODE, S_DIV, S_STAGED
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOTE = 2'b00,
    CMD_HOLD = 2'b01,
    CMD_REST = 2'b10,
    CMD_END  = 2'b11
  } cmd_t;

  state_t                r_state;
  state_t                w_next;

  logic [ADDR_BITS-1:0]  r_rom_addr;
  logic [7:0]            r_data;
  logic [5:0]            r_rem;
  logic [2:0]            r_oct;
  logic                  r_end_seen;
  logic                  r_stg_valid;
  cmd_t                  r_stg_cmd;
  logic [PHASE_BITS-1:0] r_stg_inc;
  logic                  r_note_on;
  logic [PHASE_BITS-1:0] r_phase_inc;
  logic                  r_playing;
  logic                  r_underrun;

  cmd_t                  w_cmd;
  logic [5:0]            w_note;
  logic [5:0]            w_sel_rem;
  logic [2:0]            w_sel_oct;
  logic                  w_div_done;
  logic [2:0]            w_shamt;
  logic [17:0]           w_base;
  logic [17:0]           w_shifted;
  logic [PHASE_BITS-1:0] w_stage_inc;
  logic                  w_stage;
  logic                  w_consume;

  function automatic logic [17:0] base_lut(input logic [3:0] semi);
    logic [17:0] v;
    case (semi)
      4'd0:    v = 18'd11430;
      4'd1:    v = 18'd12110;
      4'd2:    v = 18'd12830;
      4'd3:    v = 18'd13593;
      4'd4:    v = 18'd14401;
      4'd5:    v = 18'd15257;
      4'd6:    v = 18'd16164;
      4'd7:    v = 18'd17125;
      4'd8:    v = 18'd18144;
      4'd9:    v = 18'd19223;
      4'd10:   v = 18'd20366;
      4'd11:   v = 18'd21577;
      default: v = 18'd0;
    endcase
    return v;
  endfunction

  assign w_cmd     = cmd_t'(r_data[7:6]);
  assign w_consume = tick_clk && song_clk && r_playing;

`ifdef PULSE_SEQ_TRANSPOSE_EN
  logic [7:0] w_sum;
  assign w_sum = {2'b00, r_data[5:0]} + {{3{transpose[4]}}, transpose};
  always_comb begin
    w_note = w_sum[5:0];
    if (w_sum[7])      w_note = 6'd0;
    else if (w_sum[6]) w_note = 6'd63;
  end
`else
  assign w_note = r_data[5:0];
`endif

  // DECODE resolves octave 0 itself; DIV then spends exactly one clk per further
  // octave, so the shared stage path sees either the raw note or the remainder.
  always_comb begin
    w_sel_rem = w_note;
    w_sel_oct = 3'd0;
    if (r_state == S_DIV) begin
      w_sel_rem = r_rem;
      w_sel_oct = r_oct;
    end
  end

  assign w_div_done  = (w_sel_rem < 6'd12);
  assign w_shamt     = 3'd5 - w_sel_oct;
  assign w_base      = base_lut(w_sel_rem[3:0]);
  assign w_shifted   = w_base >> w_shamt;
  assign w_stage_inc = PHASE_BITS'(w_shifted) << (PHASE_BITS - 18);
  assign w_stage     = w_div_done &&
                       (((r_state == S_DECODE) && (w_cmd != CMD_END)) ||
                        (r_state == S_DIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_ADDR;
    end else if (stop) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_next = S_IDLE;
        S_ADDR:   w_next = S_READ;
        S_READ:   w_next = S_DECODE;
        S_DECODE: begin
          if (w_cmd == CMD_END) w_next = r_end_seen ? S_IDLE : S_ADDR;
          else if (w_div_done)  w_next = S_STAGED;
          else                  w_next = S_DIV;
        end
        S_DIV:    if (w_div_done) w_next = S_STAGED;
        S_STAGED: if (w_consume)  w_next = S_ADDR;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr  <= '0;
      r_data      <= '0;
      r_rem       <= '0;
      r_oct       <= '0;
      r_end_seen  <= 1'b0;
      r_stg_valid <= 1'b0;
      r_stg_cmd   <= CMD_NOTE;
      r_stg_inc   <= '0;
      r_note_on   <= 1'b0;
      r_phase_inc <= '0;
      r_playing   <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (start) begin
      r_rom_addr  <= '0;
      r_end_seen  <= 1'b0;
      r_stg_valid <= 1'b0;
      r_note_on   <= 1'b0;
      r_playing   <= 1'b1;
      r_underrun  <= 1'b0;
    end else if (stop) begin
      r_stg_valid <= 1'b0;
      r_note_on   <= 1'b0;
      r_playing   <= 1'b0;
    end else begin
      if (w_consume) begin
        if (r_stg_valid) begin
          r_note_on   <= (r_stg_cmd != CMD_REST);
          if (r_stg_cmd == CMD_NOTE) r_phase_inc <= r_stg_inc;
          r_stg_valid <= 1'b0;
          r_rom_addr  <= r_rom_addr + ADDR_BITS'(1);
        end else begin
          r_underrun  <= 1'b1;
        end
      end

      case (r_state)
        S_READ: r_data <= rom_data;
        S_DECODE: begin
          if (w_cmd == CMD_END) begin
            r_end_seen <= 1'b1;
            r_rom_addr <= ADDR_BITS'(LOOP_ADDR);
            if (r_end_seen) begin
              r_playing <= 1'b0;
              r_note_on <= 1'b0;
            end
          end else begin
            r_end_seen <= 1'b0;
            if (!w_div_done) begin
              r_rem <= w_note - 6'd12;
              r_oct <= 3'd1;
            end
          end
        end
        S_DIV: begin
          if (!w_div_done) begin
            r_rem <= r_rem - 6'd12;
            r_oct <= r_oct + 3'd1;
          end
        end
        default: ;
      endcase

      if (w_stage) begin
        r_stg_valid <= 1'b1;
        r_stg_cmd   <= w_cmd;
        r_stg_inc   <= w_stage_inc;
      end
    end
  end

  assign rom_addr     = r_rom_addr;
  assign note_on      = r_note_on;
  assign note_trigger = r_stg_valid && (r_stg_cmd == CMD_NOTE);
  assign phase_inc    = r_phase_inc;
  assign playing      = r_playing;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: registered ROM model, hand-computed phase
// increments, immediate assertions at each check.
module tb_pulse_sequencer;
  localparam int unsigned PB = 18;
  localparam int unsigned AB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_clk = 1'b0;
  logic          song_clk = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AB-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          note_on;
  logic          note_trigger;
  logic [PB-1:0] phase_inc;
  logic          playing;
  logic          underrun;
`ifdef PULSE_SEQ_TRANSPOSE_EN
  logic [4:0]    transpose = 5'd0;
`endif

  logic [7:0] rom [256];
  int n_checks = 0;
  int n_fail = 0;

  pulse_sequencer #(.PHASE_BITS(PB), .ADDR_BITS(AB), .LOOP_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .tick_clk(tick_clk), .song_clk(song_clk),
    .start(start), .stop(stop), .rom_addr(rom_addr), .rom_data(rom_data),
`ifdef PULSE_SEQ_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .note_on(note_on), .note_trigger(note_trigger), .phase_inc(phase_inc),
    .playing(playing), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic consume_raw();
    tick_clk = 1'b1;
    song_clk = 1'b1;
    step();
    tick_clk = 1'b0;
    song_clk = 1'b0;
  endtask

  task automatic consume(input string tag, input logic exp_trig);
    tick_clk = 1'b1;
    song_clk = 1'b1;
    chk(tag, note_trigger, exp_trig);
    step();
    tick_clk = 1'b0;
    song_clk = 1'b0;
  endtask

  initial begin
    fill_rom(8'hC0);
    wait_clks(3);
    chk("rst_note_on", note_on, 0);
    chk("rst_trigger", note_trigger, 0);
    chk("rst_phase", phase_inc, 0);
    chk("rst_playing", playing, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_addr", rom_addr, 0);
    rst_n = 1'b1;
    step();
    consume_raw();
    chk("idle_consume_underrun", underrun, 0);
    chk("idle_playing", playing, 0);

    // NOTE 57 -> octave 4, semi 9: 19223 >> 1
    fill_rom(8'hC0);
    rom[0] = 8'h39;
    pulse_start();
    chk("t1_playing", playing, 1);
    chk("t1_trig_early", note_trigger, 0);
    wait_clks(12);
    consume("t1_trig", 1);
    chk("t1_note_on", note_on, 1);
    chk("t1_phase", phase_inc, 9611);
    chk("t1_addr", rom_addr, 1);
    chk("t1_trig_after", note_trigger, 0);
    chk("t1_underrun", underrun, 0);

    // NOTE 60, HOLD 0, REST 0
    fill_rom(8'hC0);
    rom[0] = 8'h3C;
    rom[1] = 8'h40;
    rom[2] = 8'h80;
    pulse_start();
    chk("t2_note_on_start", note_on, 0);
    wait_clks(12);
    consume("t2_trig_note", 1);
    chk("t2_on_note", note_on, 1);
    chk("t2_phase_note", phase_inc, 11430);
    wait_clks(12);
    consume("t2_trig_hold", 0);
    chk("t2_on_hold", note_on, 1);
    chk("t2_phase_hold", phase_inc, 11430);
    wait_clks(12);
    consume("t2_trig_rest", 0);
    chk("t2_on_rest", note_on, 0);
    chk("t2_phase_rest", phase_inc, 11430);

    // NOTE 0, NOTE 63, END -> loop back to address 0
    fill_rom(8'hC0);
    rom[0] = 8'h00;
    rom[1] = 8'h3F;
    rom[2] = 8'hC0;
    pulse_start();
    wait_clks(12);
    consume("t3_trig0", 1);
    chk("t3_phase0", phase_inc, 357);
    wait_clks(12);
    consume("t3_trig63", 1);
    chk("t3_phase63", phase_inc, 13593);
    chk("t3_on63", note_on, 1);
    wait_clks(12);
    consume("t3_trig_loop", 1);
    chk("t3_phase_loop", phase_inc, 357);
    chk("t3_addr_loop", rom_addr, 1);
    chk("t3_playing", playing, 1);

    // all-END ROM
    fill_rom(8'hC0);
    pulse_start();
    wait_clks(3);
    chk("t4_playing_early", playing, 1);
    wait_clks(7);
    chk("t4_playing", playing, 0);
    chk("t4_note_on", note_on, 0);
    chk("t4_trig", note_trigger, 0);

    // consume before anything is staged
    fill_rom(8'hC0);
    rom[0] = 8'h39;
    pulse_start();
    wait_clks(2);
    consume("t5_trig", 0);
    chk("t5_underrun", underrun, 1);
    chk("t5_note_on", note_on, 0);
    chk("t5_playing", playing, 1);
    wait_clks(12);
    consume("t5_trig_late", 1);
    chk("t5_underrun_sticky", underrun, 1);
    chk("t5_phase_late", phase_inc, 9611);
    pulse_start();
    chk("t5_underrun_clr", underrun, 0);

    // stop while the next note is in DIV
    fill_rom(8'hC0);
    rom[0] = 8'h39;
    rom[1] = 8'h39;
    pulse_start();
    wait_clks(12);
    consume("t6_trig", 1);
    chk("t6_note_on", note_on, 1);
    wait_clks(3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t6_playing", playing, 0);
    chk("t6_note_on_stop", note_on, 0);
    chk("t6_phase_held", phase_inc, 9611);
    wait_clks(4);
    consume_raw();
    chk("t6_no_underrun", underrun, 0);
    wait_clks(12);
    chk("t6_no_trig", note_trigger, 0);
    chk("t6_still_idle", playing, 0);

    // start wins over simultaneous stop
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("t7_start_prio", playing, 1);
    chk("t7_addr", rom_addr, 0);

    // address wrap after 256 HOLD steps
    fill_rom(8'h40);
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      wait_clks(6);
      consume_raw();
    end
    chk("t8_addr_wrap", rom_addr, 0);
    chk("t8_underrun", underrun, 0);
    chk("t8_note_on", note_on, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
